// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one registered ALU.
//   Round-robin grant in IDLE, latch operands, drive the ALU for one issue
//   cycle, wait out ALU_LAT, then hold the result for the owner's response
//   handshake. Unsupported opcodes are answered with resp_err without
//   touching the ALU port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b   request channel per requester (ready is combinational)
//   alu_op/left/right         registered ALU inputs
//   alu_result/zero           ALU outputs
//   respN_valid/ready         response channel per requester
//   resp_result/zero/err      shared response payload
module alu_share_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_left,
  output logic [DATA_W-1:0] alu_right,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [1:0]          r_resp_valid;
  logic [1:0]          w_resp_valid_nxt;
  logic                r_owner;
  logic                r_last_grant;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_alu_left;
  logic [DATA_W-1:0]   r_alu_right;
  logic [DATA_W-1:0]   r_resp_result;
  logic                r_resp_zero;
  logic                r_resp_err;

  logic [1:0]          w_req_valid;
  logic [1:0]          w_req_ready;
  logic [1:0]          w_resp_ready;
  logic                w_grant;
  logic                w_hs;
  logic                w_legal;
  logic                w_capture;
  logic [OP_W-1:0]     w_op;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  // Opcodes the attached ALU implements.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  endfunction

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_resp_ready = {resp1_ready, resp0_ready};

  // Round-robin: on contention the requester that did not win last time gets it.
  assign w_grant = w_req_valid[1] & (~w_req_valid[0] | ~r_last_grant);

  assign w_op    = w_grant ? req1_op : req0_op;
  assign w_a     = w_grant ? req1_a  : req0_a;
  assign w_b     = w_grant ? req1_b  : req0_b;
  assign w_legal = op_legal(w_op);
  assign w_hs    = |w_req_ready;
  assign w_capture = (r_state == S_WAIT) && (r_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_resp_valid <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= w_resp_valid_nxt;
    end
  end

  // Next state, wait counter, response valids and request readies.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_resp_valid_nxt = r_resp_valid;
    w_req_ready      = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_req_valid) begin
          w_req_ready[w_grant] = 1'b1;
          if (w_legal) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt                = S_RESP;
            w_resp_valid_nxt[w_grant]  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // ALU samples its inputs at the end of this cycle.
        w_cnt_nxt   = CNT_W'(ALU_LAT - 1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt               = S_RESP;
          w_resp_valid_nxt[r_owner] = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        // Only the owner's ready completes the response.
        if (w_resp_ready[r_owner]) begin
          w_state_nxt      = S_IDLE;
          w_resp_valid_nxt = '0;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_resp_valid_nxt = '0;
      end
    endcase
  end

  // Operand latch, ALU drive registers and response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_alu_op      <= '0;
      r_alu_left    <= '0;
      r_alu_right   <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        if (w_legal) begin
          // ALU port only changes when entering ISSUE.
          r_alu_op    <= w_op;
          r_alu_left  <= w_a;
          r_alu_right <= w_b;
        end else begin
          r_resp_result <= '0;
          r_resp_zero   <= 1'b0;
          r_resp_err    <= 1'b1;
        end
      end
      if (w_capture) begin
        r_resp_result <= alu_result;
        r_resp_zero   <= alu_zero;
        r_resp_err    <= 1'b0;
      end
    end
  end

  assign req0_ready  = w_req_ready[0];
  assign req1_ready  = w_req_ready[1];
  assign alu_op      = r_alu_op;
  assign alu_left    = r_alu_left;
  assign alu_right   = r_alu_right;
  assign resp0_valid = r_resp_valid[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a registered one-cycle ALU model.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]        req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_left, alu_right, alu_result;
  logic              alu_zero;
  logic              resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero, resp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          owner;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic [3:0]  last_op    = 4'd0;
  logic [31:0] last_left  = 32'd0;
  logic [31:0] last_right = 32'd0;

  alu_share_arbiter #(.DATA_W(DATA_W), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // ALU model: op 7 returns the smaller operand; zero flags equal operands.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    alu_f = a & b;
      4'd1:    alu_f = a | b;
      4'd2:    alu_f = a + b;
      4'd6:    alu_f = a - b;
      4'd7:    alu_f = (a < b) ? a : b;
      4'd12:   alu_f = ~(a | b);
      default: alu_f = 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_result <= alu_f(alu_op, alu_left, alu_right);
    alu_zero   <= (alu_left == alu_right);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rv(input bit p);
    return p ? resp1_valid : resp0_valid;
  endfunction

  function automatic logic rr(input bit p);
    return p ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input bit p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_op"},  64'(alu_op), 64'd0);
    check({tag, "_alu_lr"},  {alu_left, alu_right}, 64'd0);
    check({tag, "_resp"},    {resp_result, 29'd0, resp_zero, resp_err, 1'b0}, 64'd0);
    check({tag, "_valids"},  {60'd0, resp0_valid, resp1_valid, req0_ready, req1_ready}, 64'd0);
  endtask

  // Issue one request from port p; call just after a rising edge.
  task automatic issue(input bit p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic ee,
                       input int elat, input bit finish_hs);
    int t;
    int lat;
    exp_t e;
    set_req(p, 1'b1, op, a, b);
    t = 0;
    @(negedge clk);
    while (!rr(p) && t < 20) begin @(negedge clk); t++; end
    check("accept", 64'(rr(p)), 64'd1);
    check("accept_other", 64'(rr(!p)), 64'd0);
    if (!rr(p)) begin
      set_req(p, 1'b0, op, a, b);
      return;
    end
    e.owner = p; e.res = er; e.zero = ez; e.err = ee;
    sb_q.push_back(e);
    @(posedge clk); #1;
    set_req(p, 1'b0, 4'd0, 32'd0, 32'd0);
    lat = 1;
    @(negedge clk);
    if (!ee) begin
      last_op = op; last_left = a; last_right = b;
    end
    check("alu_op", 64'(alu_op), 64'(last_op));
    check("alu_lr", {alu_left, alu_right}, {last_left, last_right});
    while (!rv(p) && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    check("latency", 64'(lat), 64'(elat));
    if (finish_hs) begin @(posedge clk); #1; end
  endtask

  // Monitor: pop and compare on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (resp0_valid || resp1_valid)) begin
        check("resp_overlap", 64'(resp0_valid & resp1_valid), 64'd0);
        if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
          if (sb_q.size() == 0) begin
            check("unexpected_resp", 64'(resp_result), 64'hDEAD);
          end else begin
            e = sb_q.pop_front();
            check("resp_owner", 64'(resp1_valid), 64'(e.owner));
            check("resp_result", 64'(resp_result), 64'(e.res));
            check("resp_flags", {62'd0, resp_zero, resp_err}, {62'd0, e.zero, e.err});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int t;
    rst = 1'b1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add from requester 0.
    issue(0, 4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 3, 1'b1);

    // Requester 1: subtract to zero, then op 7.
    issue(1, 4'd6, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 3, 1'b1);
    issue(1, 4'd7, 32'd3, 32'd8, 32'd3, 1'b0, 1'b0, 3, 1'b1);

    // Both valid every cycle: grants alternate 0,1,0,1.
    set_req(0, 1'b1, 4'd0, 32'h0000_F0F0, 32'h0000_0FF0);
    set_req(1, 1'b1, 4'd1, 32'h0000_F0F0, 32'h0000_0FF0);
    for (int i = 0; i < 4; i++) begin
      t = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && t < 20) begin @(negedge clk); t++; end
      check("alt_grant", {62'd0, req0_ready, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd2);
      e.owner = (i % 2 == 1);
      e.res   = (i % 2 == 1) ? 32'h0000_FFF0 : 32'h0000_00F0;
      e.zero  = 1'b0;
      e.err   = 1'b0;
      sb_q.push_back(e);
      last_op = (i % 2 == 1) ? 4'd1 : 4'd0;
      last_left = 32'h0000_F0F0;
      last_right = 32'h0000_0FF0;
      @(posedge clk); #1;
      if (i == 3) begin
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      end
    end
    repeat (6) @(posedge clk); #1;

    // Unsupported opcode: immediate error response, ALU port untouched.
    issue(0, 4'd5, 32'd11, 32'd22, 32'd0, 1'b0, 1'b1, 1, 1'b1);
    @(negedge clk);
    check("illegal_alu_hold", {28'd0, alu_op, alu_left}, {28'd0, last_op, last_left});
    @(posedge clk); #1;

    // Response backpressure with requester 1 waiting.
    resp0_ready = 1'b0;
    issue(0, 4'd2, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 3, 1'b0);
    @(posedge clk); #1;
    set_req(1, 1'b1, 4'd2, 32'd10, 32'd20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_result, 30'd0, resp0_valid, req1_ready}, {32'd3, 30'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_no_grant", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_grant", 64'(req1_ready), 64'd1);
    e.owner = 1'b1; e.res = 32'd30; e.zero = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    last_op = 4'd2; last_left = 32'd10; last_right = 32'd20;
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (6) @(posedge clk); #1;

    // Reset during WAIT aborts; round-robin pointer returns to requester 0.
    set_req(0, 1'b1, 4'd2, 32'd4, 32'd4);
    @(negedge clk);
    check("rst_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_resp", {62'd0, resp0_valid, resp1_valid}, 64'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'd2, 32'd100, 32'd1);
    set_req(1, 1'b1, 4'd2, 32'd7, 32'd7);
    @(negedge clk);
    check("rst_first_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
    e.owner = 1'b0; e.res = 32'd101; e.zero = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    t = 0;
    @(negedge clk);
    while (!req1_ready && t < 20) begin @(negedge clk); t++; end
    check("rst_second_grant", 64'(req1_ready), 64'd1);
    e.owner = 1'b1; e.res = 32'd14; e.zero = 1'b1; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered ALU (one-cycle output latency, opcodes 0/1/2/6/7/12) between two requesters, e.g. the execute stage and a multi-cycle address/compare helper.
- Round-robin arbitration and a valid/ready handshake on each request and response port.
- Latches the granted operands, drives the ALU, waits out its latency and returns the result/zero to the winning requester.
- Rejects unsupported opcodes without using the ALU.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- ALU_LAT, 1, clock edges from the ALU input being sampled to its result being valid; range 1..7.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  4  ALU operation code
- req0_a  in  DATA_W  left operand
- req0_b  in  DATA_W  right operand
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
- alu_op  out  4  to ALU_Operation
- alu_left  out  DATA_W  to ALU in_left
- alu_right  out  DATA_W  to ALU in_right
- alu_result  in  DATA_W  from ALU_Result
- alu_zero  in  1  from ALU Zero
- resp0_valid  out  1  response pending for requester 0
- resp0_ready  in  1  requester 0 consumes response
- resp1_valid  out  1  response pending for requester 1
- resp1_ready  in  1  requester 1 consumes response
- resp_result  out  DATA_W  shared response data
- resp_zero  out  1  shared zero flag (operands equal)
- resp_err  out  1  1 = unsupported opcode, no ALU operation performed

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - alu_op/alu_left/alu_right=0; resp_result=0, resp_zero=0, resp_err=0.
  - All valid/ready outputs 0.
  - rst mid-operation aborts the operation; the in-flight ALU result is discarded.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Both valid: grant the requester that is not last_grant. One valid: grant it. reqX_ready never asserts for an unvalid requester.
  - On the handshake edge, latch op/a/b and owner, and set last_grant=owner.
  - Legal op (0,1,2,6,7,12): go to ISSUE.
  - Illegal op: go to RESP with resp_err=1, resp_result=0, resp_zero=0; the ALU port is not updated.
- ISSUE:
  - alu_op/left/right driven from the latched registers. These outputs change only on entry to ISSUE and hold otherwise.
  - The ALU samples at this edge. Load wait counter = ALU_LAT-1, go to WAIT.
- WAIT:
  - Counter 0: capture alu_result, alu_zero into the resp registers, resp_err=0, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - resp<owner>_valid=1, other resp valid=0. Data held stable until handshake.
  - On resp<owner>_ready=1, go to IDLE. The next grant is possible in that IDLE cycle, not in the same cycle as the response handshake.
- Latency, legal op: accept edge E0; resp valid visible in the cycle after edge E0+ALU_LAT+1. With ALU_LAT=1: 3 cycles after acceptance, minimum 4-cycle throughput per op.
- Latency, illegal op: resp valid in the cycle after E0.
- One operation is in flight at a time; requests during non-IDLE states are stalled (ready=0) with no loss.
- Response backpressure: RESP holds indefinitely while ready=0. The ready of the non-owner requester is ignored.
- alu_zero/alu_result are passed through unmodified; the arbiter performs no arithmetic.

Test Plan:
- Reset, then req0 valid op=2 a=5 b=7 -> req0_ready=1 in the first IDLE cycle; alu_op=2, left=5, right=7 during ISSUE; resp0_valid 3 cycles after accept with resp_result=12, resp_zero=0, resp_err=0.
- Both valid every cycle, ops 0 and 1 (a=0xF0F0, b=0x0FF0) -> grants alternate 0,1,0,1; resp_result 0x00F0 to requester 0, 0xFFF0 to requester 1; resp1_valid never overlaps resp0_valid.
- req1 op=6 a=9 b=9 -> resp1_valid with result=0, zero=1. Then op=7 a=3 b=8 -> result=3.
- req0 op=5 -> resp0_valid the cycle after accept; resp_err=1, result=0; alu_* ports unchanged.
- resp0_ready held 0 for 10 cycles with req1 valid -> resp0 data stable, req1_ready=0 throughout. After resp0_ready=1, req1 is granted in the next cycle.
- rst asserted during WAIT -> next cycle all outputs at reset values, no response issued; first request after reset granted to requester 0 when both are valid.
